// File: rtl/lifo_pop_streamer.sv
// lifo_pop_streamer
//   Downstream stage of the 8-bit LIFO. Issues pops (lifo_rn) against the
//   LIFO empty flag and credit, captures lifo_dataout RD_LAT cycles later
//   into an in-order skid buffer, and presents the buffer head as a
//   valid/ready stream. A drain command pops the whole stack and pulses
//   drain_done once everything has been delivered.
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   enable        level; pop continuously while data and credit exist
//   drain_req     single-cycle pulse; pop until LIFO empty, then report done
//   lifo_empty    LIFO empty flag
//   lifo_dataout  LIFO read data (valid RD_LAT cycles after lifo_rn)
//   lifo_rn       pop strobe to the LIFO (combinational)
//   out_data      stream data, head of skid buffer
//   out_valid     stream valid
//   out_ready     consumer ready
//   busy          FSM not idle, words in flight, or buffer non-empty
//   drain_done    one-cycle pulse when a drain completes
//   pop_count     total pops issued, wraps modulo 2^CNT_W
//
// FSM states
//   state | meaning
//   IDLE  | no pops issued; buffered / in-flight words still stream out
//   RUN   | pop while enable=1, LIFO not empty and credit available
//   DRAIN | pop until LIFO empty and pipe + buffer empty; inputs ignored
//   DONE  | one cycle, drain_done asserted, then back to IDLE

module lifo_pop_streamer #(
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             drain_req,
  input  logic             lifo_empty,
  input  logic [DW-1:0]    lifo_dataout,
  output logic             lifo_rn,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             drain_done,
  output logic [CNT_W-1:0] pop_count
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  // wide enough for occ + inflight even if the credit rule were violated
  localparam int CW = $clog2(BUF_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [RD_LAT-1:0] vld_pipe;
  logic [DW-1:0]     mem [BUF_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     inflight;
  logic [CW:0]       credit_used;
  logic              popping_state;
  logic              cap;
  logic              deq;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(vld_pipe[i]);
    end
  end

  // Credit covers every word already popped but not yet handed to the
  // consumer. A same-cycle dequeue earns no credit, so the buffer can never
  // be written while full.
  assign credit_used   = {1'b0, occ} + {1'b0, inflight};
  assign popping_state = (state == RUN) || (state == DRAIN);
  // Gated by reset so no pop leaks out during a mid-operation reset cycle.
  assign lifo_rn       = !reset && popping_state && !lifo_empty &&
                         (credit_used < (CW+1)'(BUF_DEPTH));

  assign cap        = vld_pipe[RD_LAT-1];
  assign out_valid  = (occ != '0);
  assign deq        = out_valid && out_ready;
  assign out_data   = mem[rd_ptr];
  assign busy       = (state != IDLE) || (|vld_pipe) || out_valid;
  assign drain_done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      vld_pipe  <= '0;
      occ       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pop_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (drain_req)   state <= DRAIN;
          else if (enable) state <= RUN;
        end
        RUN: begin
          if (drain_req)   state <= DRAIN;
          else if (!enable) state <= IDLE;
        end
        DRAIN: begin
          if (lifo_empty && (vld_pipe == '0) && !lifo_rn && (occ == '0)) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      vld_pipe[0] <= lifo_rn;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end

      if (cap) begin
        mem[wr_ptr] <= lifo_dataout;
        wr_ptr      <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end

      if (deq) begin
        rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end

      case ({cap, deq})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase

      if (lifo_rn) pop_count <= pop_count + CNT_W'(1);
    end
  end

  // A capture into a full buffer with no dequeue would drop a word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(cap && !deq && (occ == CW'(BUF_DEPTH))));
    end
  end

endmodule
